// File: rtl/hs_pkg.sv
// Shared definitions for the req/ack handshake controllers: FSM state encoding and
// default parameter values common to the source and destination sides.
package hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_DROP = 2'd2
    } hs_state_t;

    localparam int HS_WIDTH       = 8;
    localparam int HS_SYNC_STAGES = 2;
    localparam int HS_TIMEOUT     = 1024;

endpackage

// File: rtl/hs_source_ctrl_p_sync_chain.sv
// sync_chain: single-bit multi-flop synchroniser with synchronous active-high reset.
// Used for ack on the source side and for request on the destination side.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/hs_source_ctrl_p.sv
// Source-side controller for a 4-phase req/ack clock-domain handshake.
// Optional wait-state timeout flag is built when HS_TIMEOUT_EN is defined.
module hs_source_ctrl_p
    import hs_pkg::*;
#(
    parameter int WIDTH       = HS_WIDTH,
    parameter int SYNC_STAGES = HS_SYNC_STAGES,
    parameter int TIMEOUT     = HS_TIMEOUT
) (
    input  logic             clk_s,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ack,
    output logic             request,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
`ifdef HS_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             xfer_done
);

    if (WIDTH < 1 || SYNC_STAGES < 2 || TIMEOUT < 2) begin : g_param_check
        $error("hs_source_ctrl_p: illegal parameter value");
    end

    hs_state_t state;
    logic      ack_s;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk_s),
        .rst(rst),
        .d  (ack),
        .q  (ack_s)
    );

    // A stale ack_s seen in IDLE is deliberately ignored; only REQ/DROP look at it.
    always_ff @(posedge clk_s) begin
        if (rst) begin
            state     <= HS_IDLE;
            request   <= 1'b0;
            d_out     <= '0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            unique case (state)
                HS_IDLE: begin
                    if (in_valid) begin
                        d_out   <= in_data;
                        request <= 1'b1;
                        state   <= HS_REQ;
                    end
                end
                HS_REQ: begin
                    if (ack_s) begin
                        request <= 1'b0;
                        state   <= HS_DROP;
                    end
                end
                HS_DROP: begin
                    if (!ack_s) begin
                        xfer_done <= 1'b1;
                        state     <= HS_IDLE;
                    end
                end
                default: begin
                    request <= 1'b0;
                    state   <= HS_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == HS_IDLE) && !rst;
    assign busy     = (state != HS_IDLE);

`ifdef HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             advance;

    // Mirrors the FSM transition conditions so the counter restarts on every state change.
    always_comb begin
        advance = 1'b0;
        unique case (state)
            HS_IDLE: advance = in_valid;
            HS_REQ:  advance = ack_s;
            HS_DROP: advance = !ack_s;
            default: advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk_s) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (advance) begin
                wait_cnt <= '0;
            end else if (state != HS_IDLE && wait_cnt != CNT_W'(TIMEOUT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hs_source_ctrl_p.sv
// Directed self-checking bench for hs_source_ctrl_p with a word scoreboard.
// Timeout checks are compiled in when HS_TIMEOUT_EN is defined.
module tb_hs_source_ctrl_p;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 16;

    logic             clk_s = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ack;
    logic             request;
    logic [WIDTH-1:0] d_out;
    logic             busy;
    logic             xfer_done;
`ifdef HS_TIMEOUT_EN
    logic             timeout_err;
`endif

    always #5 clk_s = ~clk_s;

    hs_source_ctrl_p #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_s      (clk_s),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ack        (ack),
        .request    (request),
        .d_out      (d_out),
        .busy       (busy),
`ifdef HS_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .xfer_done  (xfer_done)
    );

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] held;
    logic             prev_req;
    logic [1:0]       req_hist;
    bit               auto_ack;
    bit               accepted;
    int               xfer_cnt;
    int               rise_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log an accepted word, advance to the falling edge, score outputs, run ack model.
    task automatic step();
        #1;
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(in_data);
        @(negedge clk_s);
        if (request && !prev_req) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                check("request_without_word", 32'(exp_q.size()), 32'd1);
            end else begin
                held = exp_q.pop_front();
                check("d_out_at_request", 32'(d_out), 32'(held));
            end
        end
        if (busy) check("d_out_stable", 32'(d_out), 32'(held));
        if (xfer_done) xfer_cnt++;
        prev_req = request;
        if (auto_ack) begin
            ack      = req_hist[1];
            req_hist = {req_hist[0], request};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w [3];
        int xs;
        int rs;
        int idx;

        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ack = 1'b0;
        auto_ack = 1'b0; req_hist = '0; prev_req = 1'b0; held = '0;
        xfer_cnt = 0; rise_cnt = 0; accepted = 1'b0;
        @(negedge clk_s);

        // Reset state
        repeat (5) step();
        rst = 1'b0;
        #1;
        check("rst_request",   32'(request),   32'd0);
        check("rst_d_out",     32'(d_out),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_xfer_done", 32'(xfer_done), 32'd0);
`ifdef HS_TIMEOUT_EN
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif

        // Single transfer with a manually timed ack
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        check("t2_request_rise", 32'(request),  32'd1);
        check("t2_busy",         32'(busy),     32'd1);
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_data = 8'h3C;
        step(); step();
        ack = 1'b1;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            step();
            check("t2_request_held", 32'(request), 32'd1);
        end
        step();
        check("t2_request_fall", 32'(request), 32'd0);
        check("t2_busy_drop",    32'(busy),    32'd1);
        step(); step();
        ack = 1'b0;
        xs = xfer_cnt;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            step();
            check("t2_xfer_done_early", 32'(xfer_done), 32'd0);
        end
        step();
        check("t2_xfer_done",  32'(xfer_done), 32'd1);
        check("t2_in_ready",   32'(in_ready),  32'd1);
        check("t2_busy_idle",  32'(busy),      32'd0);
        check("t2_d_out_hold", 32'(d_out),     32'hA5);
        step();
        check("t2_xfer_done_pulse", 32'(xfer_done), 32'd0);
        check("t2_xfer_count",      32'(xfer_cnt - xs), 32'd1);

        // Streaming three words against the auto-responding ack model
        auto_ack = 1'b1; req_hist = '0;
        xs = xfer_cnt; rs = rise_cnt; idx = 0;
        in_valid = 1'b1; in_data = w[0];
        for (int c = 0; c < 200 && (xfer_cnt - xs) < 3; c++) begin
            step();
            if (accepted) idx++;
            if (idx >= 3) in_valid = 1'b0;
            in_data = (in_ready && idx < 3) ? w[idx] : WIDTH'($urandom);
        end
        in_valid = 1'b0;
        check("t3_xfer_count",  32'(xfer_cnt - xs), 32'd3);
        check("t3_request_cnt", 32'(rise_cnt - rs), 32'd3);
        check("t3_words_sent",  32'(idx),           32'd3);
        check("t3_sb_empty",    32'(exp_q.size()),  32'd0);
        check("t3_last_d_out",  32'(d_out),         32'h03);
        auto_ack = 1'b0; ack = 1'b0;
        repeat (3) step();

        // Stale ack already high before the word is offered
        ack = 1'b1;
        repeat (4) step();
        check("t4_idle_request", 32'(request),  32'd0);
        check("t4_idle_ready",   32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        check("t4_request_rise", 32'(request), 32'd1);
        in_valid = 1'b0;
        step();
        check("t4_req_exit", 32'(request), 32'd0);
        check("t4_busy",     32'(busy),    32'd1);
        xs = xfer_cnt;
        repeat (3) step();
        check("t4_no_done_while_ack", 32'(xfer_cnt - xs), 32'd0);
        check("t4_still_busy",        32'(busy),          32'd1);
        ack = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            step();
            check("t4_xfer_done_early", 32'(xfer_done), 32'd0);
        end
        step();
        check("t4_xfer_done", 32'(xfer_done), 32'd1);
        check("t4_d_out",     32'(d_out),     32'h5A);
        step();

        // Reset in the middle of REQ
        in_valid = 1'b1; in_data = 8'hC3;
        step();
        check("t5_request_rise", 32'(request), 32'd1);
        in_valid = 1'b0;
        step();
        check("t5_request_wait", 32'(request), 32'd1);
        xs = xfer_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_request_abort", 32'(request),  32'd0);
        check("t5_in_ready",      32'(in_ready), 32'd1);
        check("t5_busy",          32'(busy),     32'd0);
        check("t5_d_out_cleared", 32'(d_out),    32'd0);
        repeat (5) step();
        check("t5_no_xfer_done", 32'(xfer_cnt - xs), 32'd0);

`ifdef HS_TIMEOUT_EN
        // Timeout with ack never returned
        check("t6_err_before", 32'(timeout_err), 32'd0);
        in_valid = 1'b1; in_data = 8'h7E;
        step();
        check("t6_request_rise", 32'(request), 32'd1);
        in_valid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) step();
        check("t6_err_not_yet", 32'(timeout_err), 32'd0);
        step();
        check("t6_err_rise", 32'(timeout_err), 32'd1);
        repeat (20) step();
        check("t6_err_sticky",  32'(timeout_err), 32'd1);
        check("t6_request_on",  32'(request),     32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_err_cleared", 32'(timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
